// File: rtl/dmem_responder.sv
// dmem_responder: single-port data-memory slave for the core's load/store port.
// One request at a time over a valid/ready handshake, a configurable number of
// wait states, then one response over a second valid/ready handshake.
// Optional feature macro: RISCX_DMEM_ERR_EN (adds misalignment/range error checks).
module dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_wen_i,
    input  logic [3:0]  req_wmask_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q;
    logic          reqReady_q;
    logic          rspValid_q;
    logic [31:0]   rspRdata_q;
    logic [3:0]    cnt_q;
    logic [31:0]   addr_q;
    logic          wen_q;
    logic [3:0]    wmask_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          execNow;
    logic [31:0]   accAddr;
    logic          accWen;
    logic [3:0]    accWmask;
    logic [31:0]   accWdata;
    logic [31:0]   accOffset;
    logic [AW-1:0] wordIdx;
    logic          accErr;
    logic [31:0]   rdata_d;

    assign accept = req_valid_i & reqReady_q & (state_q == IDLE);

    // With zero wait states the access uses the live request; otherwise the latched copy.
    always_comb begin
        accAddr  = addr_q;
        accWen   = wen_q;
        accWmask = wmask_q;
        accWdata = wdata_q;
        if (WAIT_CYCLES == 0) begin
            accAddr  = req_addr_i;
            accWen   = req_wen_i;
            accWmask = req_wmask_i;
            accWdata = req_wdata_i;
        end
    end

    assign accOffset = accAddr - BASE_ADDR;
    assign wordIdx   = AW'(accOffset >> 2);

`ifdef RISCX_DMEM_ERR_EN
    logic err_q;
    assign accErr = (accAddr[1:0] != 2'b00)
                 || ({1'b0, accAddr} <  {1'b0, BASE_ADDR})
                 || ({1'b0, accAddr} >= ({1'b0, BASE_ADDR} + 33'(4 * DEPTH)));
    assign rsp_err_o = err_q;
`else
    assign accErr    = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // The access fires on the accepting edge (no wait states) or when the counter hits 1; never under reset.
    always_comb begin
        execNow = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE:    execNow = accept && (WAIT_CYCLES == 0);
                WAIT:    execNow = (cnt_q <= 4'd1);
                default: execNow = 1'b0;
            endcase
        end
    end

    assign rdata_d = (!accWen && !accErr) ? mem[wordIdx] : 32'h0;

    // Byte-masked write into the array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (execNow && accWen && !accErr) begin
            for (int b = 0; b < 4; b++) begin
                if (accWmask[b]) begin
                    mem[wordIdx][8*b +: 8] <= accWdata[8*b +: 8];
                end
            end
        end
    end

    // Request/response FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            reqReady_q <= 1'b0;
            rspValid_q <= 1'b0;
            rspRdata_q <= 32'h0;
            cnt_q      <= 4'd0;
            addr_q     <= 32'h0;
            wen_q      <= 1'b0;
            wmask_q    <= 4'h0;
            wdata_q    <= 32'h0;
`ifdef RISCX_DMEM_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    reqReady_q <= 1'b1;
                    if (accept) begin
                        addr_q     <= req_addr_i;
                        wen_q      <= req_wen_i;
                        wmask_q    <= req_wmask_i;
                        wdata_q    <= req_wdata_i;
                        reqReady_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q    <= RESP;
                            rspValid_q <= 1'b1;
                            rspRdata_q <= rdata_d;
`ifdef RISCX_DMEM_ERR_EN
                            err_q      <= accErr;
`endif
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WaitCnt;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_q      <= 4'd0;
                        state_q    <= RESP;
                        rspValid_q <= 1'b1;
                        rspRdata_q <= rdata_d;
`ifdef RISCX_DMEM_ERR_EN
                        err_q      <= accErr;
`endif
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q    <= IDLE;
                        reqReady_q <= 1'b1;
                        rspValid_q <= 1'b0;
                        rspRdata_q <= 32'h0;
`ifdef RISCX_DMEM_ERR_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    reqReady_q <= 1'b0;
                    rspValid_q <= 1'b0;
                    rspRdata_q <= 32'h0;
                end
            endcase
        end
    end

    assign req_ready_o = reqReady_q;
    assign rsp_valid_o = rspValid_q;
    assign rsp_rdata_o = rspRdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: reset, write/read, byte masks,
// backpressure, error handling, reset mid-transaction and latency for 0/1/3 wait states.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    // Main DUT, one wait state
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        reqWen;
    logic [3:0]  reqWmask;
    logic [31:0] reqWdata;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;

    // Shared inputs of the zero- and three-wait-state instances
    logic        bValid;
    logic [31:0] bAddr;
    logic        bWen;
    logic [3:0]  bWmask;
    logic [31:0] bWdata;
    logic        bRspReady;
    logic        ready0, valid0, err0;
    logic [31:0] rdata0;
    logic        ready3, valid3, err3;
    logic [31:0] rdata3;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] gotData;
    logic        gotErr;
    int          gotLat;

    dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(reqValid), .req_ready_o(reqReady), .req_addr_i(reqAddr),
        .req_wen_i(reqWen), .req_wmask_i(reqWmask), .req_wdata_i(reqWdata),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_rdata_o(rspRdata),
        .rsp_err_o(rspErr)
    );

    dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(bValid), .req_ready_o(ready0), .req_addr_i(bAddr),
        .req_wen_i(bWen), .req_wmask_i(bWmask), .req_wdata_i(bWdata),
        .rsp_valid_o(valid0), .rsp_ready_i(bRspReady), .rsp_rdata_o(rdata0),
        .rsp_err_o(err0)
    );

    dmem_responder #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(bValid), .req_ready_o(ready3), .req_addr_i(bAddr),
        .req_wen_i(bWen), .req_wmask_i(bWmask), .req_wdata_i(bWdata),
        .rsp_valid_o(valid3), .rsp_ready_i(bRspReady), .rsp_rdata_o(rdata3),
        .rsp_err_o(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge so outputs are sampled away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic wen,
                                 input logic [3:0] mask, input logic [31:0] wdata,
                                 input logic rdy);
        reqValid = valid;
        reqAddr  = addr;
        reqWen   = wen;
        reqWmask = mask;
        reqWdata = wdata;
        rspReady = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full transaction on the main DUT; lat = edges from acceptance to rsp_valid, -1 on timeout
    task automatic transact(input logic [31:0] addr, input logic wen, input logic [3:0] mask,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int lat);
        lat   = -1;
        rdata = 32'hx;
        err   = 1'bx;
        applyStimulus(1'b1, addr, wen, mask, wdata, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            if (rspValid) begin
                lat   = k - 1;
                rdata = rspRdata;
                err   = rspErr;
                break;
            end
            tick();
        end
        tick();
    endtask

    initial begin
        applyStimulus(1'b1, 32'h8000_0010, 1'b1, 4'hF, 32'h1234_5678, 1'b1);
        bValid = 1'b0; bAddr = 32'h0; bWen = 1'b0; bWmask = 4'h0; bWdata = 32'h0; bRspReady = 1'b1;
        rst_n = 1'b0;

        // Reset held for three cycles with a request pending
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset ready", {31'h0, reqReady}, 32'h0);
            checkOutput("reset valid", {31'h0, rspValid}, 32'h0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        rst_n = 1'b1;
        tick();
        checkOutput("ready after reset", {31'h0, reqReady}, 32'h1);
        checkOutput("valid after reset", {31'h0, rspValid}, 32'h0);
        checkOutput("rdata after reset", rspRdata, 32'h0);
        checkOutput("err after reset", {31'h0, rspErr}, 32'h0);

        // Full-word write then read back
        transact(32'h8000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, gotData, gotErr, gotLat);
        checkOutput("write latency", 32'(gotLat), 32'd1);
        checkOutput("write rdata", gotData, 32'h0);
        checkOutput("write err", {31'h0, gotErr}, 32'h0);
        transact(32'h8000_0010, 1'b0, 4'h0, 32'h0, gotData, gotErr, gotLat);
        checkOutput("read latency", 32'(gotLat), 32'd1);
        checkOutput("read rdata", gotData, 32'hDEAD_BEEF);
        checkOutput("ready after read", {31'h0, reqReady}, 32'h1);

        // Byte-masked merge
        transact(32'h8000_0020, 1'b1, 4'hF, 32'h1122_3344, gotData, gotErr, gotLat);
        transact(32'h8000_0020, 1'b1, 4'b0101, 32'hAABB_CCDD, gotData, gotErr, gotLat);
        transact(32'h8000_0020, 1'b0, 4'h0, 32'h0, gotData, gotErr, gotLat);
        checkOutput("mask merge", gotData, 32'h11BB_33DD);
        transact(32'h8000_0020, 1'b1, 4'h0, 32'hFFFF_FFFF, gotData, gotErr, gotLat);
        checkOutput("zero mask latency", 32'(gotLat), 32'd1);
        transact(32'h8000_0020, 1'b0, 4'h0, 32'h0, gotData, gotErr, gotLat);
        checkOutput("zero mask unchanged", gotData, 32'h11BB_33DD);

        // Backpressure on a read response
        applyStimulus(1'b1, 32'h8000_0010, 1'b0, 4'h0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp valid", {31'h0, rspValid}, 32'h1);
            checkOutput("bp rdata", rspRdata, 32'hDEAD_BEEF);
            checkOutput("bp ready", {31'h0, reqReady}, 32'h0);
            tick();
        end
        rspReady = 1'b1;
        tick();
        checkOutput("bp release valid", {31'h0, rspValid}, 32'h0);
        checkOutput("bp release rdata", rspRdata, 32'h0);
        checkOutput("bp release ready", {31'h0, reqReady}, 32'h1);

        // Error handling (or wraparound when the error feature is absent)
        transact(32'h8000_0000, 1'b1, 4'hF, 32'hA5A5_A5A5, gotData, gotErr, gotLat);
        transact(32'h8000_0FFC, 1'b1, 4'hF, 32'h600D_F00D, gotData, gotErr, gotLat);
        transact(32'h8000_0002, 1'b0, 4'h0, 32'h0, gotData, gotErr, gotLat);
        checkOutput("misaligned latency", 32'(gotLat), 32'd1);
`ifdef RISCX_DMEM_ERR_EN
        checkOutput("misaligned err", {31'h0, gotErr}, 32'h1);
        checkOutput("misaligned rdata", gotData, 32'h0);
`else
        checkOutput("misaligned err", {31'h0, gotErr}, 32'h0);
        checkOutput("misaligned rdata", gotData, 32'hA5A5_A5A5);
`endif
        transact(32'h7FFF_FFFC, 1'b1, 4'hF, 32'h0BAD_BEEF, gotData, gotErr, gotLat);
`ifdef RISCX_DMEM_ERR_EN
        checkOutput("below base err", {31'h0, gotErr}, 32'h1);
`else
        checkOutput("below base err", {31'h0, gotErr}, 32'h0);
`endif
        transact(32'h8000_0FFC, 1'b0, 4'h0, 32'h0, gotData, gotErr, gotLat);
`ifdef RISCX_DMEM_ERR_EN
        checkOutput("top word after bad write", gotData, 32'h600D_F00D);
`else
        checkOutput("top word after wrapped write", gotData, 32'h0BAD_BEEF);
`endif
        transact(32'h8000_0000, 1'b0, 4'h0, 32'h0, gotData, gotErr, gotLat);
        checkOutput("word0 intact", gotData, 32'hA5A5_A5A5);

        // Reset between acceptance and execution drops the write
        transact(32'h8000_0030, 1'b1, 4'hF, 32'hCAFE_F00D, gotData, gotErr, gotLat);
        applyStimulus(1'b1, 32'h8000_0030, 1'b1, 4'hF, 32'h5555_AAAA, 1'b1);
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mid reset valid", {31'h0, rspValid}, 32'h0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
        rst_n = 1'b1;
        tick();
        transact(32'h8000_0030, 1'b0, 4'h0, 32'h0, gotData, gotErr, gotLat);
        checkOutput("dropped write", gotData, 32'hCAFE_F00D);

        // Latency sweep: zero and three wait states
        bValid = 1'b1; bAddr = 32'h8000_0040; bWen = 1'b1; bWmask = 4'hF; bWdata = 32'h0000_0077;
        bRspReady = 1'b0;
        tick();
        bValid = 1'b0;
        checkOutput("w0 valid at accept", {31'h0, valid0}, 32'h1);
        checkOutput("w3 valid at accept", {31'h0, valid3}, 32'h0);
        tick();
        checkOutput("w3 valid +1", {31'h0, valid3}, 32'h0);
        tick();
        checkOutput("w3 valid +2", {31'h0, valid3}, 32'h0);
        tick();
        checkOutput("w3 valid +3", {31'h0, valid3}, 32'h1);
        checkOutput("w0 held", {31'h0, valid0}, 32'h1);
        bRspReady = 1'b1;
        tick();
        checkOutput("w0 cleared", {31'h0, valid0}, 32'h0);
        checkOutput("w3 cleared", {31'h0, valid3}, 32'h0);
        bValid = 1'b1; bWen = 1'b0; bWmask = 4'h0; bWdata = 32'h0;
        tick();
        bValid = 1'b0;
        checkOutput("w0 read data", rdata0, 32'h0000_0077);
        tick();
        checkOutput("w0 read done", {31'h0, valid0}, 32'h0);
        tick();
        tick();
        checkOutput("w3 read valid", {31'h0, valid3}, 32'h1);
        checkOutput("w3 read data", rdata3, 32'h0000_0077);
        checkOutput("w3 read err", {31'h0, err3}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
